// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - fixed-priority arbiter sharing one VRAM port between display, clear engine and writer
// Optional feature macro: VRAM_BLANK_ONLY_EN (writes only during vertical blanking).
module vram_arbiter #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 1200,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              slot_open;
    logic              disp_grant;
    logic              clr_grant;
    logic              wr_grant;

`ifdef VRAM_BLANK_ONLY_EN
    // Writes only while the beam is in vertical blanking, so the picture never tears.
    assign slot_open = vblank && !disp_req;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign slot_open     = !disp_req;
`endif

    // Display wins unconditionally; the writer is locked out for the whole clear and
    // during its own ack cycle, so a held request lands exactly once.
    always_comb begin
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        disp_grant = 1'b0;
        clr_grant  = 1'b0;
        wr_grant   = 1'b0;
        if (rst) begin
            if (disp_req) begin
                disp_grant = 1'b1;
                mem_addr   = disp_addr;
            end else if (state == CLEAR) begin
                if (slot_open) begin
                    clr_grant = 1'b1;
                    mem_addr  = clr_cnt;
                    mem_wdata = CLEAR_VAL;
                    mem_we    = 1'b1;
                end
            end else if (wr_req && !wr_ack && slot_open) begin
                wr_grant  = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                mem_we    = 1'b1;
            end
        end
    end

    assign disp_data = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
            wr_ack     <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= disp_grant;
            wr_ack     <= wr_grant;
            clr_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_grant) begin
                        if (clr_cnt == LAST_ADDR) begin
                            state    <= IDLE;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with VRAM model and rule-based scoreboard
module tb_vram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1200;
    localparam int NWORDS = 1 << ADDR_W;
`ifdef VRAM_BLANK_ONLY_EN
    localparam bit BLANK_ONLY = 1'b1;
`else
    localparam bit BLANK_ONLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              vblank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .vblank(vblank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment VRAM (written by the DUT) and the bench's own expected contents.
    logic [DATA_W-1:0] vram   [NWORDS];
    logic [DATA_W-1:0] shadow [NWORDS];

    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected per-cycle behaviour derived from the arbitration rules.
    bit m_clear, m_dv, m_ack, m_done;
    int m_cnt, m_rd_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            bit slot, gd, gc, gw, e_we;
            int ea, ed;
            slot = !disp_req && (!BLANK_ONLY || vblank);
            gd = rst && disp_req;
            gc = rst && !disp_req && m_clear && slot;
            gw = rst && !disp_req && !m_clear && wr_req && !m_ack && slot;
            e_we = gc || gw;
            ea = gd ? int'(disp_addr) : gc ? m_cnt : gw ? int'(wr_addr) : 0;
            ed = gc ? 0 : gw ? int'(wr_data) : 0;
            check("sb_mem_we", 32'(mem_we), 32'(e_we));
            check("sb_mem_addr", 32'(mem_addr), 32'(ea));
            if (e_we || !rst) check("sb_mem_wdata", 32'(mem_wdata), 32'(ed));
            check("sb_disp_valid", 32'(disp_valid), 32'(m_dv));
            check("sb_wr_ack", 32'(wr_ack), 32'(m_ack));
            check("sb_clr_busy", 32'(clr_busy), 32'(m_clear));
            check("sb_clr_done", 32'(clr_done), 32'(m_done));
            if (m_dv) check("sb_disp_data", 32'(disp_data), 32'(shadow[m_rd_addr]));
            if (gc) shadow[m_cnt] = 8'h00;
            if (gw) shadow[wr_addr] = wr_data;
            if (!rst) begin
                m_clear = 0; m_cnt = 0; m_dv = 0; m_ack = 0; m_done = 0;
            end else begin
                m_dv = gd;
                m_rd_addr = int'(disp_addr);
                m_ack = gw;
                m_done = 0;
                if (!m_clear && clr_start) begin
                    m_clear = 1;
                    m_cnt = 0;
                end else if (gc) begin
                    if (m_cnt == DEPTH - 1) begin
                        m_clear = 0;
                        m_done = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic rd_check(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        disp_req = 1'b1;
        disp_addr = a;
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 32'(disp_valid), 32'd1);
        check(name, 32'(disp_data), 32'(e));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int nclr, done_cyc, ack_cyc, wcyc, nwe;
        bit seen, got_ack;
        for (int i = 0; i < NWORDS; i++) begin
            vram[i] = 8'hC3;
            shadow[i] = 8'hC3;
        end
        vram[5] = 8'hA5;
        shadow[5] = 8'hA5;
        rst = 1'b0; vblank = 1'b0; disp_req = 1'b1; disp_addr = 11'd7;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0;

        // 1: reset holds the VRAM port quiet even with a display request present
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b1; disp_req = 1'b0; disp_addr = '0; vblank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({disp_valid, wr_ack, clr_busy, clr_done, mem_we, mem_addr}), 32'd0);
            tick();
        end

        // 2: display read
        disp_req = 1'b1; disp_addr = 11'd5;
        @(negedge clk);
        check("t2_mem_addr", 32'(mem_addr), 32'd5);
        check("t2_mem_we", 32'(mem_we), 32'd0);
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        check("t2_disp_valid", 32'(disp_valid), 32'd1);
        check("t2_disp_data", 32'(disp_data), 32'hA5);
        tick();

        // 3: writer stalled by display for 3 cycles, then exactly one write
        wr_req = 1'b1; wr_addr = 11'h10; wr_data = 8'h3C; disp_req = 1'b1; disp_addr = 11'h40;
        nwe = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            tick();
        end
        check("t3_stall_writes", 32'(nwe), 32'd0);
        disp_req = 1'b0;
        @(negedge clk);
        check("t3_we", 32'(mem_we), 32'd1);
        check("t3_addr", 32'(mem_addr), 32'h10);
        check("t3_data", 32'(mem_wdata), 32'h3C);
        tick();
        @(negedge clk);
        check("t3_ack", 32'(wr_ack), 32'd1);
        check("t3_no_rewrite", 32'(mem_we), 32'd0);
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        check("t3_ack_single", 32'(wr_ack), 32'd0);
        tick();
        rd_check("t3_readback", 11'h10, 8'h3C);

        // 4: full clear with a stalled writer and an ignored second clr_start
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0; wr_req = 1'b1; wr_addr = 11'h20; wr_data = 8'h55;
        nclr = 0; done_cyc = -1; ack_cyc = -1;
        for (int i = 0; i < 1400 && ack_cyc < 0; i++) begin
            @(negedge clk);
            if (i == 0) check("t4_busy_next_cycle", 32'(clr_busy), 32'd1);
            if (mem_we && clr_busy) nclr++;
            if (clr_done) done_cyc = i;
            if (wr_ack) ack_cyc = i;
            tick();
            clr_start = (i == 100);
            if (ack_cyc >= 0) wr_req = 1'b0;
        end
        check("t4_clear_writes", 32'(nclr), 32'd1200);
        check("t4_done_cycle", 32'(done_cyc), 32'd1200);
        check("t4_ack_after_done", 32'(ack_cyc), 32'd1201);
        rd_check("t4_rd0", 11'd0, 8'h00);
        rd_check("t4_rd5", 11'd5, 8'h00);
        rd_check("t4_rd1199", 11'd1199, 8'h00);
        rd_check("t4_rd1200", 11'd1200, 8'hC3);
        rd_check("t4_rd_writer", 11'h20, 8'h55);

        // 5: reset mid-clear aborts it; a new clear restarts from address 0
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 700 && !seen; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 11'd600) seen = 1'b1;
            tick();
        end
        check("t5_reached_600", 32'(seen), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (clr_busy || clr_done || mem_we) seen = 1'b1;
            tick();
        end
        check("t5_aborted_quiet", 32'(seen), 32'd0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        @(negedge clk);
        check("t5_restart_we", 32'(mem_we), 32'd1);
        check("t5_restart_addr", 32'(mem_addr), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 1300 && !seen; i++) begin
            tick();
            @(negedge clk);
            if (clr_done) seen = 1'b1;
        end
        check("t5_restart_done", 32'(seen), 32'd1);
        tick();

        // 6: writer during active video (vblank=0), blanking starts three cycles later
        vblank = 1'b0; disp_req = 1'b0;
        wr_req = 1'b1; wr_addr = 11'h30; wr_data = 8'h77;
        wcyc = -1; got_ack = 1'b0;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wcyc = i;
                check("t6_addr", 32'(mem_addr), 32'h30);
                check("t6_data", 32'(mem_wdata), 32'h77);
            end
            if (wr_ack) got_ack = 1'b1;
            tick();
            if (i == 2) vblank = 1'b1;
            if (got_ack) wr_req = 1'b0;
        end
        check("t6_write_cycle", 32'(wcyc), BLANK_ONLY ? 32'd3 : 32'd0);
        check("t6_ack", 32'(got_ack), 32'd1);
        vblank = 1'b1;
        rd_check("t6_readback", 11'h30, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
